// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : Shared types and encodings for the multi-cycle RV32 control unit.
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWRITE = 4'd4,
        S_MEMWB    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_SUB    = 2'b01,
        ALUOP_DECODE = 2'b10
    } alu_op_e;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage
`default_nettype wire

// File: rtl/riscv_alu_dec.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_alu_dec
//  Purpose  : Maps ALU op class and instruction fields to an ALU control code.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_alu_dec
    import riscv_pkg::*;
(
    input  alu_op_e     alu_op_i,
    input  logic [2:0]  funct3_i,
    input  logic        op5_i,
    input  logic        funct7b5_i,
    output logic [2:0]  alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_DECODE: begin
                case (funct3_i)
                    // Only register-register forms can encode subtract.
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mc_ctrl
//  Purpose  : Moore FSM sequencing the shared multi-cycle RV32 datapath.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_mc_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned XLen = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [6:0]  op_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        mem_write_o,
    output logic        adr_src_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        reg_write_o,
    output logic [1:0]  result_src_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  imm_src_o,
    output logic [2:0]  alu_control_o,
    output logic        retire_o,
    output logic        illegal_o
);

    if (XLen != 32) begin : g_xlen_check
        $error("riscv_mc_ctrl: only XLen = 32 is supported");
    end

    state_e  state_q, state_d;
    alu_op_e alu_op;
    logic    mem_req, mem_write, ir_write, pc_write, reg_write, retire, illegal;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        adr_src_o    = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        retire       = 1'b0;
        illegal      = 1'b0;
        result_src_o = RES_ALUOUT;
        alu_src_a_o  = SRCA_PC;
        alu_src_b_o  = SRCB_RD2;
        alu_op       = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req      = 1'b1;
                alu_src_b_o  = SRCB_FOUR;
                result_src_o = RES_ALURESULT;
                ir_write     = mem_ready_i;
                pc_write     = mem_ready_i;
                if (mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_IMM;
                case (op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_IALU:      state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = SRCA_RD1;
                alu_src_b_o = SRCB_IMM;
                state_d     = (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req   = 1'b1;
                adr_src_o = 1'b1;
                if (mem_ready_i) state_d = S_MEMWB;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src_o = 1'b1;
                retire    = mem_ready_i;
                if (mem_ready_i) state_d = S_FETCH;
            end
            S_MEMWB: begin
                result_src_o = RES_DATA;
                reg_write    = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a_o = SRCA_RD1;
                alu_src_b_o = SRCB_RD2;
                alu_op      = ALUOP_DECODE;
                state_d     = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a_o = SRCA_RD1;
                alu_src_b_o = SRCB_IMM;
                alu_op      = ALUOP_DECODE;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a_o = SRCA_RD1;
                alu_src_b_o = SRCB_RD2;
                alu_op      = ALUOP_SUB;
                pc_write    = zero_i;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_FOUR;
                pc_write    = 1'b1;
                state_d     = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Gate strobes with reset so nothing fires while rst_ni is held low.
    assign mem_req_o   = mem_req   & rst_ni;
    assign mem_write_o = mem_write & rst_ni;
    assign ir_write_o  = ir_write  & rst_ni;
    assign pc_write_o  = pc_write  & rst_ni;
    assign reg_write_o = reg_write & rst_ni;
    assign retire_o    = retire    & rst_ni;
    assign illegal_o   = illegal   & rst_ni;

    always_comb begin
        case (op_i)
            OP_SW:   imm_src_o = IMM_S;
            OP_BEQ:  imm_src_o = IMM_B;
            OP_JAL:  imm_src_o = IMM_J;
            default: imm_src_o = IMM_I;
        endcase
    end

    riscv_alu_dec u_alu_dec (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3_i),
        .op5_i         (op_i[5]),
        .funct7b5_i    (funct7b5_i),
        .alu_control_o (alu_control_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_riscv_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_mc_ctrl
//  Purpose  : Scoreboard bench for riscv_mc_ctrl with randomized instructions.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mc_ctrl;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [6:0] op_i;
    logic [2:0] funct3_i;
    logic       funct7b5_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o;
    logic [1:0] result_src_o, alu_src_a_o, alu_src_b_o, imm_src_o;
    logic [2:0] alu_control_o;
    logic       retire_o, illegal_o;

    riscv_mc_ctrl #(.XLen(32)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .op_i          (op_i),
        .funct3_i      (funct3_i),
        .funct7b5_i    (funct7b5_i),
        .zero_i        (zero_i),
        .mem_ready_i   (mem_ready_i),
        .mem_req_o     (mem_req_o),
        .mem_write_o   (mem_write_o),
        .adr_src_o     (adr_src_o),
        .ir_write_o    (ir_write_o),
        .pc_write_o    (pc_write_o),
        .reg_write_o   (reg_write_o),
        .result_src_o  (result_src_o),
        .alu_src_a_o   (alu_src_a_o),
        .alu_src_b_o   (alu_src_b_o),
        .imm_src_o     (imm_src_o),
        .alu_control_o (alu_control_o),
        .retire_o      (retire_o),
        .illegal_o     (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int cycles;
        int reg_w;
        int pc_w;
        int ir_w;
        int mem_req;
        int mem_wr;
        int adr1;
        int ill;
        int last_alu;
        int prev_alu;
        int chk_prev;
        int imm;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [6:0] opcode_of(input int kind);
        case (kind)
            K_LW:    return 7'b0000011;
            K_SW:    return 7'b0100011;
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_BEQ:   return 7'b1100011;
            K_JAL:   return 7'b1101111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic bit is_supported(input logic [6:0] op);
        for (int k = K_LW; k <= K_JAL; k++)
            if (opcode_of(k) == op) return 1'b1;
        return 1'b0;
    endfunction

    // Reference ALU operation for arithmetic instructions: add/sub/slt/or/and.
    function automatic int ref_alu(input int kind, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (kind == K_R && f7) ? 1 : 0;
            3'd2:    return 5;
            3'd6:    return 3;
            3'd7:    return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int ref_imm(input int kind);
        case (kind)
            K_SW:    return 1;
            K_BEQ:   return 2;
            K_JAL:   return 3;
            default: return 0;
        endcase
    endfunction

    // Monitor: accumulates per-instruction activity and scores it at each end event.
    int   m_cyc, m_rw, m_pw, m_iw, m_mr, m_mw, m_a1, m_bad, m_last, m_prev;
    exp_t m_e;

    task automatic mon_clear();
        m_cyc = 0; m_rw = 0; m_pw = 0; m_iw = 0; m_mr = 0; m_mw = 0; m_a1 = 0; m_bad = 0;
        m_last = 0; m_prev = 0;
    endtask

    initial begin : monitor
        mon_clear();
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                mon_clear();
            end else begin
                m_cyc++;
                if (reg_write_o) m_rw++;
                if (pc_write_o)  m_pw++;
                if (ir_write_o)  m_iw++;
                if (mem_req_o)   m_mr++;
                if (mem_write_o) m_mw++;
                if (adr_src_o)   m_a1++;
                if (mem_write_o && !mem_req_o) m_bad++;
                m_prev = m_last;
                m_last = int'(alu_control_o);
                if (retire_o || illegal_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_end", 32'd1, 32'd0);
                    end else begin
                        m_e = exp_q.pop_front();
                        chk("cycles",         m_cyc, m_e.cycles);
                        chk("reg_write_cnt",  m_rw,  m_e.reg_w);
                        chk("pc_write_cnt",   m_pw,  m_e.pc_w);
                        chk("ir_write_cnt",   m_iw,  m_e.ir_w);
                        chk("mem_req_cnt",    m_mr,  m_e.mem_req);
                        chk("mem_write_cnt",  m_mw,  m_e.mem_wr);
                        chk("adr_src_cnt",    m_a1,  m_e.adr1);
                        chk("write_no_req",   m_bad, 0);
                        chk("end_illegal",    illegal_o, m_e.ill);
                        chk("end_retire",     retire_o, (m_e.ill != 0) ? 0 : 1);
                        chk("imm_src",        imm_src_o, m_e.imm);
                        chk("alu_last",       m_last, m_e.last_alu);
                        if (m_e.chk_prev != 0) chk("alu_prev", m_prev, m_e.prev_alu);
                    end
                    mon_clear();
                end else if (m_cyc > 40) begin
                    chk("instr_timeout", m_cyc, 40);
                    mon_clear();
                end
            end
        end
    end

    // Drive one instruction: expectation goes on the queue, then ready follows the
    // architectural timeline; ready is randomized wherever the FSM must ignore it.
    task automatic issue(input int kind, input int fw, input int mw, input logic [2:0] f3,
                         input logic f7, input logic z, input logic [6:0] ill_op);
        exp_t e;
        bit   rdy[$];
        bit   is_mem;
        int   base [7] = '{5, 4, 4, 4, 3, 4, 2};
        is_mem = (kind == K_LW || kind == K_SW);

        for (int k = 0; k < fw; k++) rdy.push_back(1'b0);
        rdy.push_back(1'b1);
        rdy.push_back(1'($urandom_range(0, 1)));
        if (is_mem) begin
            rdy.push_back(1'($urandom_range(0, 1)));
            for (int k = 0; k < mw; k++) rdy.push_back(1'b0);
            rdy.push_back(1'b1);
            if (kind == K_LW) rdy.push_back(1'($urandom_range(0, 1)));
        end else if (kind == K_BEQ) begin
            rdy.push_back(1'($urandom_range(0, 1)));
        end else if (kind != K_ILL) begin
            rdy.push_back(1'($urandom_range(0, 1)));
            rdy.push_back(1'($urandom_range(0, 1)));
        end

        e.cycles   = base[kind] + fw + (is_mem ? mw : 0);
        e.reg_w    = (kind == K_LW || kind == K_R || kind == K_I || kind == K_JAL) ? 1 : 0;
        e.pc_w     = 1 + ((kind == K_JAL) ? 1 : 0) + ((kind == K_BEQ && z) ? 1 : 0);
        e.ir_w     = 1;
        e.mem_req  = fw + 1 + (is_mem ? mw + 1 : 0);
        e.mem_wr   = (kind == K_SW) ? mw + 1 : 0;
        e.adr1     = is_mem ? mw + 1 : 0;
        e.ill      = (kind == K_ILL) ? 1 : 0;
        e.last_alu = (kind == K_BEQ) ? 1 : 0;
        e.prev_alu = (kind == K_R || kind == K_I) ? ref_alu(kind, f3, f7) : 0;
        e.chk_prev = (kind == K_R || kind == K_I || kind == K_JAL || kind == K_LW) ? 1 : 0;
        e.imm      = ref_imm(kind);
        exp_q.push_back(e);

        op_i       = (kind == K_ILL) ? ill_op : opcode_of(kind);
        funct3_i   = f3;
        funct7b5_i = f7;
        zero_i     = z;
        foreach (rdy[k]) begin
            mem_ready_i = rdy[k];
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin : stimulus
        int         kind, fw, mw;
        logic [6:0] rop;

        rst_ni      = 1'b0;
        mem_ready_i = 1'b1;
        op_i        = opcode_of(K_LW);
        funct3_i    = 3'd0;
        funct7b5_i  = 1'b0;
        zero_i      = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_mem_req",   mem_req_o,   0);
        chk("rst_mem_write", mem_write_o, 0);
        chk("rst_ir_write",  ir_write_o,  0);
        chk("rst_pc_write",  pc_write_o,  0);
        chk("rst_reg_write", reg_write_o, 0);
        chk("rst_retire",    retire_o,    0);
        chk("rst_illegal",   illegal_o,   0);

        rst_ni = 1'b1;
        #1;
        chk("rel_mem_req",   mem_req_o,   1);
        chk("rel_adr_src",   adr_src_o,   0);
        chk("rel_reg_write", reg_write_o, 0);
        chk("rel_mem_write", mem_write_o, 0);

        issue(K_LW,  0, 0, 3'd0, 1'b0, 1'b0, 7'h00);
        issue(K_SW,  0, 2, 3'd2, 1'b0, 1'b0, 7'h00);
        issue(K_BEQ, 0, 0, 3'd0, 1'b0, 1'b1, 7'h00);
        issue(K_BEQ, 1, 0, 3'd0, 1'b0, 1'b0, 7'h00);
        issue(K_R,   0, 0, 3'd0, 1'b1, 1'b0, 7'h00);
        issue(K_I,   0, 0, 3'd0, 1'b1, 1'b0, 7'h00);
        issue(K_R,   0, 0, 3'd2, 1'b0, 1'b0, 7'h00);
        issue(K_I,   0, 0, 3'd6, 1'b0, 1'b0, 7'h00);
        issue(K_R,   0, 0, 3'd7, 1'b1, 1'b0, 7'h00);
        issue(K_ILL, 0, 0, 3'd0, 1'b0, 1'b0, 7'h7F);
        issue(K_JAL, 1, 0, 3'd0, 1'b0, 1'b0, 7'h00);
        issue(K_LW,  2, 3, 3'd0, 1'b0, 1'b0, 7'h00);

        // Abort a store in MEMWRITE with an asynchronous reset.
        op_i        = opcode_of(K_SW);
        mem_ready_i = 1'b1;
        @(posedge clk_i); #1;
        mem_ready_i = 1'($urandom_range(0, 1));
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0;
        #1;
        chk("abort_pre_mem_write", mem_write_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("abort_mem_write", mem_write_o, 0);
        chk("abort_mem_req",   mem_req_o,   0);
        chk("abort_retire",    retire_o,    0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        #1;

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 6);
            fw   = $urandom_range(0, 2);
            mw   = $urandom_range(0, 3);
            rop  = 7'($urandom);
            if (is_supported(rop)) rop = 7'h7F;
            issue(kind, fw, mw, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), rop);
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_mc_ctrl.md
# riscv_mc_ctrl

Control unit for the multi-cycle variant of the RV32 core. A Moore-style FSM sequences a shared datapath (single ALU, single memory port, IR/OldPC/ALUOut/Data registers) through fetch, decode, execute, memory and writeback steps. It also generates ALU and immediate-select controls and handles a ready-based handshake on the unified memory port.

## Interface
Parameters:
- `XLen`, default 32: datapath width. Used only for checking consistency with the datapath.

Ports:
- `clk_i`, in, 1: clock. All state changes on the rising edge.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `op_i`, in, 7: `IR[6:0]`.
- `funct3_i`, in, 3: `IR[14:12]`.
- `funct7b5_i`, in, 1: `IR[30]`.
- `zero_i`, in, 1: ALU zero flag.
- `mem_ready_i`, in, 1: memory accepted or completed the current request.
- `mem_req_o`, out, 1: memory request valid.
- `mem_write_o`, out, 1: memory write enable. Only ever high while `mem_req_o` is high.
- `adr_src_o`, out, 1: memory address select. 0 = PC, 1 = Result.
- `ir_write_o`, out, 1: load IR and OldPC.
- `pc_write_o`, out, 1: load PC.
- `reg_write_o`, out, 1: register file write enable.
- `result_src_o`, out, 2: result mux select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a_o`, out, 2: ALU A select. 00 = PC, 01 = OldPC, 10 = RD1.
- `alu_src_b_o`, out, 2: ALU B select. 00 = RD2, 01 = ImmExt, 10 = constant 4.
- `imm_src_o`, out, 2: immediate format. 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_control_o`, out, 3: ALU operation. 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `retire_o`, out, 1: one-cycle pulse in the final cycle of each legal instruction.
- `illegal_o`, out, 1: one-cycle pulse in DECODE when the opcode is unsupported.

## Operation
- Supported opcodes: lw `0000011`, sw `0100011`, R-type `0110011`, I-ALU `0010011`, beq `1100011`, jal `1101111`.
- States and transitions:
  - FETCH → DECODE when `mem_ready_i` is high; otherwise stay in FETCH.
  - DECODE → MEMADR for lw/sw, EXECUTER for R-type, EXECUTEI for I-ALU, BEQ for beq, JAL for jal, FETCH otherwise (sets `illegal_o`).
  - MEMADR → MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD → MEMWB on `mem_ready_i`.
  - MEMWRITE → FETCH on `mem_ready_i`.
  - EXECUTER and EXECUTEI → ALUWB.
  - JAL → ALUWB.
  - MEMWB, ALUWB and BEQ → FETCH.
- Per-state outputs (unlisted outputs are 0):
  - FETCH: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, add, `result_src`=10. `ir_write` and `pc_write` equal `mem_ready_i`.
  - DECODE: `alu_src_a`=01, `alu_src_b`=01, add (computes the branch target into ALUOut).
  - MEMADR: `alu_src_a`=10, `alu_src_b`=01, add.
  - MEMREAD: `mem_req`=1, `adr_src`=1, `result_src`=00.
  - MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1, `result_src`=00.
  - MEMWB: `result_src`=01, `reg_write`=1.
  - EXECUTER: `alu_src_a`=10, `alu_src_b`=00, ALU decode.
  - EXECUTEI: `alu_src_a`=10, `alu_src_b`=01, ALU decode.
  - ALUWB: `result_src`=00, `reg_write`=1.
  - BEQ: `alu_src_a`=10, `alu_src_b`=00, sub, `result_src`=00, `pc_write`=`zero_i`.
  - JAL: `alu_src_a`=01, `alu_src_b`=10, add, `result_src`=00, `pc_write`=1.
- ALU decode, applied when the ALU op class is "decode":
  - funct3 000: sub if `op_i[5]` and `funct7b5_i` are both set, else add.
  - funct3 010: slt.
  - funct3 110: or.
  - funct3 111: and.
  - any other funct3: add.
- `imm_src_o` is combinational from `op_i` in every state:
  - lw and I-ALU → 00
  - sw → 01
  - beq → 10
  - jal → 11
  - unknown → 00
- `retire_o` is high in:
  - MEMWB and ALUWB (this covers jal, which retires through ALUWB);
  - BEQ;
  - MEMWRITE, but only when `mem_ready_i` is high.

## Timing
- Reset:
  - State is FETCH while `rst_ni`=0 and on release.
  - `ir_write`, `pc_write`, `reg_write`, `mem_write`, `mem_req`, `retire` and `illegal` are forced to 0 while in reset.
  - Asserting reset mid-instruction aborts it; no write enable glitches high.
- Memory handshake:
  - `mem_req_o`, `adr_src_o` and `mem_write_o` stay stable until a cycle in which `mem_ready_i`=1. The transfer completes in that cycle.
  - `mem_ready_i` is ignored outside FETCH, MEMREAD and MEMWRITE.
- Latency with zero wait states, in cycles: lw 5, sw 4, R 4, I 4, beq 3, jal 4, illegal 2. Each wait cycle adds 1.
- Outputs depend only on state, except `ir_write`/`pc_write` in FETCH, `pc_write` in BEQ, and `retire` in MEMWRITE.

## Structure
- `riscv_pkg` holds:
  - `state_e` enum;
  - opcode localparams;
  - ALU control, result, srcA and srcB select encodings;
  - `alu_op_e` with values add, sub and decode.
- Sub-module `riscv_alu_dec` (combinational): inputs `alu_op`, `funct3`, `op5`, `funct7b5`; output `alu_control`.
- The FSM and output decode live in `riscv_mc_ctrl`.

## Test plan
- Reset check: release reset with `mem_ready_i`=1 → `mem_req_o`=1 and no write enables high until FETCH completes. Assert `rst_ni`=0 during MEMWRITE → `mem_write_o` drops to 0 asynchronously and the FSM restarts in FETCH.
- lw, `op_i`=0000011, `mem_ready_i` stuck at 1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; `reg_write_o` and `retire_o` high in cycle 5 only.
- sw with 2 wait states in MEMWRITE → `mem_write_o` high for 3 cycles with `adr_src_o`=1 throughout; `retire_o` in the third cycle only.
- beq → `pc_write_o`=1 in BEQ when `zero_i`=1 and 0 when `zero_i`=0; instruction takes 3 cycles either way.
- R-type funct3 000 with `funct7b5`=1 → `alu_control_o`=001 in EXECUTER. Same encoding in EXECUTEI (`op_i[5]`=0) → 000. funct3 010 → 101; 110 → 011; 111 → 010.
- `op_i`=1111111 → `illegal_o` pulses in DECODE, next state FETCH, no `reg_write_o` and no `retire_o`. jal → `pc_write_o` in JAL, then `reg_write_o` in ALUWB.
